// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: the loader FSM state encoding,
// the number of bytes per instruction word and the byte-lane index width.
// Optional feature macro used by the loader: PROGRAM_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
package loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      BYTES,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } loaderState_e;

   // States from which a Start pulse may open a new load session.
   function automatic logic isRestartable(input loaderState_e s);
      return (s == IDLE) || (s == DONE) || (s == ERROR);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects four stream bytes, least significant byte first, into one 32-bit
// instruction word.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   clear_i     in   restart the lane counter (new load session)
//   shiftEn_i   in   a payload byte is accepted this cycle
//   byte_i      in   payload byte
//   word_o      out  word including byte_i; valid when wordFull_o is high
//   wordFull_o  out  byte_i completes the current word this cycle
// ---------------------------------------------------------------------------
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        shiftEn_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        wordFull_o
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
   localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [31:0]       shift_q, shift_d;

   // Bytes enter at the top and move down, so after four shifts the first
   // byte received sits in bits [7:0]. The lane counter wraps naturally.
   always_comb begin
      lane_d  = lane_q;
      shift_d = shift_q;
      if (clear_i) begin
         lane_d = '0;
      end else if (shiftEn_i) begin
         lane_d  = lane_q + LANE_ONE;
         shift_d = {byte_i, shift_q[31:8]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q  <= '0;
         shift_q <= '0;
      end else begin
         lane_q  <= lane_d;
         shift_q <= shift_d;
      end
   end

   // The completed word is presented combinationally in the same cycle as
   // the fourth byte so the loader can capture it without an extra stage.
   assign word_o     = {byte_i, shift_q[31:8]};
   assign wordFull_o = shiftEn_i && !clear_i && (lane_q == LAST_LANE);

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Writer side of the instruction memory. Receives a byte stream (length byte
// N followed by 4*N payload bytes, little-endian words) and writes the words
// into the program RAM starting at byte address 0, holding the CPU in reset
// while the load is in progress.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to expect one trailing
// byte equal to the XOR of all payload bytes; a mismatch ends in ERROR.
// Parameters:
//   MEMORY_DEPTH  words in the program RAM (largest accepted N)
//   DATA_WIDTH    instruction width (4 bytes per word)
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   Start         in   pulse; opens a load session from IDLE/DONE/ERROR
//   ByteValid     in   ByteData valid this cycle
//   ByteData      in   stream byte
//   ByteReady     out  loader accepts ByteData this cycle
//   MemWrite      out  one-cycle RAM write strobe
//   WriteAddress  out  byte address of the word being written
//   WriteData     out  assembled instruction word
//   CpuHold       out  processor reset while loading
//   Done          out  load completed, held until next Start/reset
//   Error         out  bad length or checksum, held until next Start/reset
// ---------------------------------------------------------------------------
module program_loader
   import loader_pkg::*;
#(
   parameter int MEMORY_DEPTH = 32,
   parameter int DATA_WIDTH   = 32
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic                  ByteValid,
   input  logic [7:0]            ByteData,
   output logic                  ByteReady,
   output logic                  MemWrite,
   output logic [31:0]           WriteAddress,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error
);

   localparam int              CW      = $clog2(MEMORY_DEPTH + 1);
   localparam logic [CW-1:0]   IDX_ONE = CW'(1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam loaderState_e AFTER_LAST = CHECK;
`else
   localparam loaderState_e AFTER_LAST = DONE;
`endif

   loaderState_e          state_q, state_d;
   logic [CW-1:0]         wordCount_q, wordCount_d;
   logic [CW-1:0]         wordIndex_q, wordIndex_d;
   logic [31:0]           writeAddress_q, writeAddress_d;
   logic [DATA_WIDTH-1:0] writeData_q, writeData_d;

   logic                  acceptByte;
   logic                  transfer;
   logic                  startLoad;
   logic                  lenZero;
   logic                  lenTooBig;
   logic                  payloadByte;
   logic                  lastWord;
   logic                  wordFull;
   logic [31:0]           assembledWord;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]            xor_q, xor_d;
`endif

   // Readiness depends only on the current state, so transfer never feeds
   // back into itself through the next-state logic.
   assign acceptByte  = (state_q == LEN) || (state_q == BYTES) || (state_q == CHECK);
   assign transfer    = ByteValid && acceptByte;
   assign startLoad   = Start && isRestartable(state_q);
   assign lenZero     = (ByteData == 8'd0);
   assign lenTooBig   = int'(ByteData) > MEMORY_DEPTH;
   assign payloadByte = (state_q == BYTES) && transfer;
   assign lastWord    = (wordIndex_q + IDX_ONE) == wordCount_q;

   word_assembler u_wordAssembler (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (startLoad),
      .shiftEn_i  (payloadByte),
      .byte_i     (ByteData),
      .word_o     (assembledWord),
      .wordFull_o (wordFull)
   );

   // Next-state logic. A too-long length is rejected before any write so the
   // RAM is never addressed past its last word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (Start) state_d = LEN;
         end
         LEN: begin
            if (transfer) begin
               if (lenZero)        state_d = AFTER_LAST;
               else if (lenTooBig) state_d = ERROR;
               else                state_d = BYTES;
            end
         end
         BYTES: begin
            if (wordFull) state_d = WRITE;
         end
         WRITE: begin
            if (lastWord) state_d = AFTER_LAST;
            else          state_d = BYTES;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (transfer) begin
               if (ByteData == xor_q) state_d = DONE;
               else                   state_d = ERROR;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates. The write address is captured together with the word
   // so both hold steady from the WRITE cycle until the next word completes.
   always_comb begin
      wordCount_d    = wordCount_q;
      wordIndex_d    = wordIndex_q;
      writeAddress_d = writeAddress_q;
      writeData_d    = writeData_q;
      if (startLoad) begin
         wordCount_d = '0;
         wordIndex_d = '0;
      end
      if ((state_q == LEN) && transfer && !lenTooBig) begin
         wordCount_d = CW'(ByteData);
      end
      if (wordFull) begin
         writeData_d    = DATA_WIDTH'(assembledWord);
         writeAddress_d = 32'(wordIndex_q) << 2;
      end
      if (state_q == WRITE) begin
         wordIndex_d = wordIndex_q + IDX_ONE;
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   // Running XOR over every payload byte; an empty program checks against 0.
   always_comb begin
      xor_d = xor_q;
      if (startLoad)        xor_d = 8'd0;
      else if (payloadByte) xor_d = xor_q ^ ByteData;
   end
`endif

   // Register bank; reset aborts any load in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         wordCount_q    <= '0;
         wordIndex_q    <= '0;
         writeAddress_q <= '0;
         writeData_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         xor_q          <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         wordCount_q    <= wordCount_d;
         wordIndex_q    <= wordIndex_d;
         writeAddress_q <= writeAddress_d;
         writeData_q    <= writeData_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         xor_q          <= xor_d;
`endif
      end
   end

   // Moore outputs decoded from the state register.
   assign ByteReady    = acceptByte;
   assign MemWrite     = (state_q == WRITE);
   assign CpuHold      = (state_q == LEN) || (state_q == BYTES) ||
                         (state_q == WRITE) || (state_q == CHECK);
   assign Done         = (state_q == DONE);
   assign Error        = (state_q == ERROR);
   assign WriteAddress = writeAddress_q;
   assign WriteData    = writeData_q;

endmodule
